// File: rtl/equifill_req_arbiter.sv
// equifill_req_arbiter
//   Shares one equifilling strip allocator among N_REQ requesters. A
//   round-robin pick selects one placement request (height, width), which is
//   sent to the allocator as a single transaction. The strike/x/y result is
//   then returned to the winning requester. The block also sequences
//   allocator clears (flush), rejects zero-sized requests locally, and runs a
//   watchdog that forces a strike if the allocator never answers.
//
// Ports
//   clk_i, rst_i          clock; asynchronous active-high reset
//   req_valid_i/ready_o   per-requester request handshake (ready one-hot/zero)
//   req_height_i/width_i  packed 6-bit sizes, requester k at [6k+5:6k]
//   rsp_valid_o/ready_i   per-requester response handshake
//   rsp_strike_o/x_o/y_o  response data (held stable while rsp_valid_o is up)
//   alloc_*               allocator issue / result / clear interface
//   flush_i               clear request (level or pulse)
//   busy_o                high whenever not IDLE
//   timeout_o             one-cycle pulse when the watchdog fires
//
// state | meaning
// IDLE  | waiting; flush has priority over requests, else round-robin grant
// FLUSH | one-cycle alloc_clear_o pulse, then back to IDLE
// ISSUE | one-cycle alloc_valid_o pulse with captured height/width
// WAIT  | waiting for alloc_done_i, guarded by the watchdog counter
// RESP  | rsp_valid_o to the granted requester until its rsp_ready_i
module equifill_req_arbiter #(
  parameter int N_REQ          = 4,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int FAIL_COORD     = 128
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [N_REQ-1:0]     req_valid_i,
  output logic [N_REQ-1:0]     req_ready_o,
  input  logic [6*N_REQ-1:0]   req_height_i,
  input  logic [6*N_REQ-1:0]   req_width_i,
  output logic [N_REQ-1:0]     rsp_valid_o,
  input  logic [N_REQ-1:0]     rsp_ready_i,
  output logic                 rsp_strike_o,
  output logic [7:0]           rsp_x_o,
  output logic [7:0]           rsp_y_o,
  output logic                 alloc_valid_o,
  output logic [5:0]           alloc_height_o,
  output logic [5:0]           alloc_width_o,
  input  logic                 alloc_done_i,
  input  logic                 alloc_strike_i,
  input  logic [7:0]           alloc_x_i,
  input  logic [7:0]           alloc_y_i,
  input  logic                 flush_i,
  output logic                 alloc_clear_o,
  output logic                 busy_o,
  output logic                 timeout_o
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [7:0]       FAIL_C   = 8'(FAIL_COORD);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_FLUSH, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] r_rr_ptr;
  logic [5:0]       r_height;
  logic [5:0]       r_width;
  logic [CNT_W-1:0] r_cnt;
  logic             r_pend_flush;
  logic             r_strike;
  logic [7:0]       r_x;
  logic [7:0]       r_y;

  logic             w_found;
  logic [IDX_W-1:0] w_cand;
  logic [IDX_W-1:0] w_grant_idx;
  logic [IDX_W-1:0] w_rr_nxt;
  logic [5:0]       w_req_h;
  logic [5:0]       w_req_w;
  logic             w_zero;
  logic             w_grant;
  logic             w_timeout;

  // First valid requester at or after the RR pointer, wrapping modulo N_REQ.
  always_comb begin
    w_found     = 1'b0;
    w_cand      = '0;
    w_grant_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_cand = IDX_W'((int'(r_rr_ptr) + i) % N_REQ);
      if (!w_found && req_valid_i[w_cand]) begin
        w_found     = 1'b1;
        w_grant_idx = w_cand;
      end
    end
  end

  always_comb begin
    w_req_h = '0;
    w_req_w = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (w_grant_idx == IDX_W'(k)) begin
        w_req_h = req_height_i[6*k +: 6];
        w_req_w = req_width_i[6*k +: 6];
      end
    end
  end

  assign w_zero   = (w_req_h == 6'd0) || (w_req_w == 6'd0);
  assign w_rr_nxt = (w_grant_idx == IDX_W'(N_REQ - 1)) ? '0 : w_grant_idx + 1'b1;

  always_comb begin
    w_state_nxt   = r_state;
    req_ready_o   = '0;
    rsp_valid_o   = '0;
    alloc_valid_o = 1'b0;
    alloc_clear_o = 1'b0;
    timeout_o     = 1'b0;
    w_grant       = 1'b0;
    w_timeout     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (flush_i || r_pend_flush) begin
          w_state_nxt = S_FLUSH;
        end else if (w_found) begin
          w_grant = 1'b1;
          // Keep ready low while reset is held so every output reads 0.
          req_ready_o[w_grant_idx] = ~rst_i;
          w_state_nxt = w_zero ? S_RESP : S_ISSUE;
        end
      end
      S_FLUSH: begin
        alloc_clear_o = 1'b1;
        w_state_nxt   = S_IDLE;
      end
      S_ISSUE: begin
        alloc_valid_o = 1'b1;
        w_state_nxt   = S_WAIT;
      end
      S_WAIT: begin
        // A result arriving on the expiry cycle wins over the watchdog.
        if (alloc_done_i) begin
          w_state_nxt = S_RESP;
        end else if (r_cnt == CNT_LAST) begin
          w_timeout   = 1'b1;
          timeout_o   = 1'b1;
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        rsp_valid_o[r_idx] = 1'b1;
        if (rsp_ready_i[r_idx]) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= S_IDLE;
      r_idx        <= '0;
      r_rr_ptr     <= '0;
      r_height     <= '0;
      r_width      <= '0;
      r_cnt        <= '0;
      r_pend_flush <= 1'b0;
      r_strike     <= 1'b0;
      r_x          <= '0;
      r_y          <= '0;
    end else begin
      r_state <= w_state_nxt;

      if (w_grant) begin
        r_idx    <= w_grant_idx;
        r_height <= w_req_h;
        r_width  <= w_req_w;
        r_rr_ptr <= w_rr_nxt;
        if (w_zero) begin
          r_strike <= 1'b1;
          r_x      <= FAIL_C;
          r_y      <= FAIL_C;
        end
      end

      if (r_state == S_ISSUE) begin
        r_cnt <= '0;
      end else if (r_state == S_WAIT) begin
        r_cnt <= r_cnt + 1'b1;
      end

      if (r_state == S_WAIT && alloc_done_i) begin
        r_strike <= alloc_strike_i;
        r_x      <= alloc_x_i;
        r_y      <= alloc_y_i;
      end else if (w_timeout) begin
        r_strike <= 1'b1;
        r_x      <= FAIL_C;
        r_y      <= FAIL_C;
      end

      // A flush seen mid-transaction is deferred, never aborting the request.
      if (r_state == S_FLUSH) begin
        r_pend_flush <= 1'b0;
      end else if (flush_i && r_state != S_IDLE) begin
        r_pend_flush <= 1'b1;
      end
    end
  end

  assign busy_o         = (r_state != S_IDLE);
  assign rsp_strike_o   = r_strike;
  assign rsp_x_o        = r_x;
  assign rsp_y_o        = r_y;
  assign alloc_height_o = r_height;
  assign alloc_width_o  = r_width;

endmodule

// File: tb/tb_equifill_req_arbiter.sv
// Directed testbench for equifill_req_arbiter: inputs change on the falling
// edge, outputs are checked 1 time unit later, state advances on the rising
// edge. Expected values are hand-computed per test.
module tb_equifill_req_arbiter;

  localparam int N = 4;

  logic           clk_i = 1'b0;
  logic           rst_i;
  logic [N-1:0]   req_valid_i;
  logic [N-1:0]   req_ready_o;
  logic [6*N-1:0] req_height_i;
  logic [6*N-1:0] req_width_i;
  logic [N-1:0]   rsp_valid_o;
  logic [N-1:0]   rsp_ready_i;
  logic           rsp_strike_o;
  logic [7:0]     rsp_x_o;
  logic [7:0]     rsp_y_o;
  logic           alloc_valid_o;
  logic [5:0]     alloc_height_o;
  logic [5:0]     alloc_width_o;
  logic           alloc_done_i;
  logic           alloc_strike_i;
  logic [7:0]     alloc_x_i;
  logic [7:0]     alloc_y_i;
  logic           flush_i;
  logic           alloc_clear_o;
  logic           busy_o;
  logic           timeout_o;

  int n_chk  = 0;
  int n_fail = 0;

  equifill_req_arbiter #(.N_REQ(N), .TIMEOUT_CYCLES(16), .FAIL_COORD(128)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_height_i   (req_height_i),
    .req_width_i    (req_width_i),
    .rsp_valid_o    (rsp_valid_o),
    .rsp_ready_i    (rsp_ready_i),
    .rsp_strike_o   (rsp_strike_o),
    .rsp_x_o        (rsp_x_o),
    .rsp_y_o        (rsp_y_o),
    .alloc_valid_o  (alloc_valid_o),
    .alloc_height_o (alloc_height_o),
    .alloc_width_o  (alloc_width_o),
    .alloc_done_i   (alloc_done_i),
    .alloc_strike_i (alloc_strike_i),
    .alloc_x_i      (alloc_x_i),
    .alloc_y_i      (alloc_y_i),
    .flush_i        (flush_i),
    .alloc_clear_o  (alloc_clear_o),
    .busy_o         (busy_o),
    .timeout_o      (timeout_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk_i);
  endtask

  task automatic set_req(input int k, input logic [5:0] h, input logic [5:0] w);
    req_height_i[6*k +: 6] = h;
    req_width_i[6*k +: 6]  = w;
  endtask

  initial begin
    #200000;
    $display("FAIL sim_watchdog: got no finish, expected finish before 200000");
    $fatal(1);
  end

  initial begin
    int k;
    rst_i = 1'b1;
    req_valid_i = '0; req_height_i = '0; req_width_i = '0; rsp_ready_i = '0;
    alloc_done_i = 1'b0; alloc_strike_i = 1'b0; alloc_x_i = '0; alloc_y_i = '0;
    flush_i = 1'b0;

    // Reset state
    nxt(); nxt(); #1;
    chk("rst_busy", busy_o, 0);
    chk("rst_rsp_valid", rsp_valid_o, 0);
    chk("rst_rsp_x", rsp_x_o, 0);
    chk("rst_alloc_valid", alloc_valid_o, 0);

    // Round-robin: all valid, allocator answers the cycle after issue
    nxt(); rst_i = 1'b0;
    for (int i = 0; i < N; i++) set_req(i, 6'(i + 1), 6'(i + 2));
    req_valid_i = 4'hF; #1;
    for (int t = 0; t < 5; t++) begin
      k = t % 4;
      chk("rr_grant", req_ready_o, 32'(1 << k));
      nxt(); #1;
      chk("rr_issue_h", alloc_height_o, k + 1);
      nxt(); alloc_done_i = 1'b1; alloc_x_i = 8'(t); alloc_y_i = 8'(t + 1); alloc_strike_i = 1'b0;
      nxt(); alloc_done_i = 1'b0; #1;
      chk("rr_rsp_valid", rsp_valid_o, 32'(1 << k));
      chk("rr_rsp_x", rsp_x_o, t);
      rsp_ready_i = 4'hF;
      if (t == 4) req_valid_i = '0;
      nxt(); rsp_ready_i = '0; #1;
    end

    // Basic issue: req0 h=8 w=20, done 3 cycles after issue
    set_req(0, 6'd8, 6'd20); req_valid_i = 4'b0001; #1;
    chk("basic_grant", req_ready_o, 4'b0001);
    nxt(); req_valid_i = '0; #1;
    chk("basic_alloc_valid", alloc_valid_o, 1);
    chk("basic_alloc_h", alloc_height_o, 8);
    chk("basic_alloc_w", alloc_width_o, 20);
    nxt(); nxt();
    nxt(); alloc_done_i = 1'b1; alloc_strike_i = 1'b0; alloc_x_i = 8'd0; alloc_y_i = 8'd48;
    nxt(); alloc_done_i = 1'b0; #1;
    chk("basic_rsp_valid", rsp_valid_o, 4'b0001);
    chk("basic_rsp_x", rsp_x_o, 0);
    chk("basic_rsp_y", rsp_y_o, 48);
    chk("basic_rsp_strike", rsp_strike_o, 0);
    chk("basic_busy", busy_o, 1);
    rsp_ready_i = 4'b0001;
    nxt(); rsp_ready_i = '0; #1;
    chk("basic_busy_fall", busy_o, 0);

    // Zero size: req2 h=0 w=10, rejected locally
    set_req(2, 6'd0, 6'd10); req_valid_i = 4'b0100; #1;
    chk("zero_grant", req_ready_o, 4'b0100);
    nxt(); req_valid_i = '0; #1;
    chk("zero_no_alloc", alloc_valid_o, 0);
    chk("zero_rsp_valid", rsp_valid_o, 4'b0100);
    chk("zero_strike", rsp_strike_o, 1);
    chk("zero_x", rsp_x_o, 128);
    chk("zero_y", rsp_y_o, 128);
    rsp_ready_i = 4'b0001;
    nxt(); #1;
    chk("zero_other_ready_ignored", rsp_valid_o, 4'b0100);
    rsp_ready_i = 4'b0100;
    nxt(); rsp_ready_i = '0; #1;
    chk("zero_done_busy", busy_o, 0);

    // Timeout: req1, allocator silent
    set_req(1, 6'd5, 6'd7); req_valid_i = 4'b0010; #1;
    chk("to_grant", req_ready_o, 4'b0010);
    nxt(); req_valid_i = '0; #1;
    chk("to_alloc_valid", alloc_valid_o, 1);
    for (int n = 1; n <= 16; n++) begin
      nxt(); #1;
      chk("to_pulse", timeout_o, (n == 16));
    end
    nxt(); alloc_done_i = 1'b1; alloc_strike_i = 1'b0; alloc_x_i = 8'd5; alloc_y_i = 8'd6; #1;
    chk("to_rsp_valid", rsp_valid_o, 4'b0010);
    chk("to_strike", rsp_strike_o, 1);
    chk("to_x", rsp_x_o, 128);
    chk("to_y", rsp_y_o, 128);
    nxt(); alloc_done_i = 1'b0; #1;
    chk("to_late_x", rsp_x_o, 128);
    chk("to_late_strike", rsp_strike_o, 1);
    rsp_ready_i = 4'b0010;
    nxt(); rsp_ready_i = '0; alloc_done_i = 1'b1; #1;
    chk("to_idle_busy", busy_o, 0);
    nxt(); alloc_done_i = 1'b0; #1;
    chk("spurious_busy", busy_o, 0);
    chk("spurious_rsp", rsp_valid_o, 0);

    // Flush during WAIT, backpressure, then reset mid-RESP
    set_req(3, 6'd4, 6'd4); req_valid_i = 4'b1000; #1;
    chk("fl_grant", req_ready_o, 4'b1000);
    nxt();
    nxt(); flush_i = 1'b1;
    nxt(); flush_i = 1'b0; #1;
    chk("fl_no_clear_wait", alloc_clear_o, 0);
    nxt(); alloc_done_i = 1'b1; alloc_strike_i = 1'b0; alloc_x_i = 8'd9; alloc_y_i = 8'd10;
    nxt(); alloc_done_i = 1'b0; #1;
    chk("fl_rsp_valid", rsp_valid_o, 4'b1000);
    chk("fl_no_clear_resp", alloc_clear_o, 0);
    for (int i = 0; i < 5; i++) begin
      chk("bp_x", rsp_x_o, 9);
      chk("bp_y", rsp_y_o, 10);
      chk("bp_no_grant", req_ready_o, 0);
      nxt(); #1;
    end
    rsp_ready_i = 4'b1000;
    nxt(); rsp_ready_i = '0; #1;
    chk("fl_idle_no_grant", req_ready_o, 0);
    chk("fl_idle_no_clear", alloc_clear_o, 0);
    nxt(); #1;
    chk("fl_clear", alloc_clear_o, 1);
    chk("fl_clear_no_grant", req_ready_o, 0);
    nxt(); #1;
    chk("fl_after_grant", req_ready_o, 4'b1000);
    chk("fl_clear_once", alloc_clear_o, 0);
    nxt(); req_valid_i = '0;
    nxt(); alloc_done_i = 1'b1; alloc_x_i = 8'd77; alloc_y_i = 8'd78;
    nxt(); alloc_done_i = 1'b0; #1;
    chk("rst_pre_rsp", rsp_valid_o, 4'b1000);
    rst_i = 1'b1; #1;
    chk("rst_mid_rsp_valid", rsp_valid_o, 0);
    chk("rst_mid_busy", busy_o, 0);
    chk("rst_mid_x", rsp_x_o, 0);
    chk("rst_mid_alloc_h", alloc_height_o, 0);
    nxt(); rst_i = 1'b0; #1;
    chk("rst_after_busy", busy_o, 0);
    chk("rst_after_rsp", rsp_valid_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
